// File: rtl/vga_scan.sv
// 640x480@60 VGA scan stage: pixel-enable divider, h/v counters, running frame-buffer
// address, and a one-pixel output register that keeps RGB and syncs aligned.
module vga_scan #(
  parameter int CLK_DIV = 4,
  parameter int RAM_LAT = 1,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ramaddrb,
  input  logic [11:0]       ramdoutb,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C    = HW'(H_VIS);
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VIS - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C    = VW'(V_VIS);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VIS - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC - 1);

  // The output register samples ramdoutb one pixel period after the address moves,
  // so the RAM must answer within that window.
  if (RAM_LAT + 1 > CLK_DIV) begin : g_bad_lat
    $error("vga_scan: RAM_LAT+1 must not exceed CLK_DIV");
  end

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          pix_tick;
  logic          visible;
  logic          frame_last;
  logic          vis_last;
  logic          h_sync;
  logic          v_sync;

  // No handshake: the RAM port is always enabled and read-only; ramdoutb is
  // assumed valid RAM_LAT clks after ramaddrb changes.
  always_comb begin
    pix_tick   = (div_cnt == DIV_LAST);
    visible    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    vis_last   = (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST);
    h_sync     = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    v_sync     = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      ramaddrb    <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && frame_last;
      div_cnt     <= pix_tick ? '0 : div_cnt + DW'(1);
      if (pix_tick) begin
        h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + HW'(1);
        if (h_cnt == H_LAST) begin
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end
        // Wrapping right after the last visible pixel keeps the address inside
        // the frame buffer through vertical blanking; it is already 0 at (0,0).
        if (frame_last || vis_last) begin
          ramaddrb <= '0;
        end else if (visible) begin
          ramaddrb <= ramaddrb + ADDR_W'(1);
        end
        {vga_r, vga_g, vga_b} <= visible ? ramdoutb : 12'h000;
        vga_hs <= ~h_sync;
        vga_vs <= ~v_sync;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: a full-size instance for pixel data and line timing, and a
// shrunken-timing instance (16x10 total, 8x6 visible) for whole-frame behaviour.
module tb_vga_scan;

  localparam int CLK_DIV = 4;
  // Small instance geometry
  localparam int S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VV = 6, S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;
  localparam int S_PIX = S_HT * S_VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_ff = 1'b0;
  logic        mode_s_ff = 1'b0;

  logic [18:0] ramaddrb, ramaddrb_s;
  logic [11:0] dout, dout_s;
  logic [3:0]  vga_r, vga_g, vga_b, vga_r_s, vga_g_s, vga_b_s;
  logic        vga_hs, vga_vs, frame_start;
  logic        vga_hs_s, vga_vs_s, frame_start_s;
  logic [11:0] rgb, rgb_s;

  int n_checks = 0;
  int n_fail = 0;

  assign rgb   = {vga_r, vga_g, vga_b};
  assign rgb_s = {vga_r_s, vga_g_s, vga_b_s};

  always #5 clk = ~clk;

  vga_scan dut (
    .clk(clk), .rst(rst), .ramaddrb(ramaddrb), .ramdoutb(dout),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  vga_scan #(
    .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_s (
    .clk(clk), .rst(rst), .ramaddrb(ramaddrb_s), .ramdoutb(dout_s),
    .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s),
    .vga_hs(vga_hs_s), .vga_vs(vga_vs_s), .frame_start(frame_start_s)
  );

  // Frame-buffer models with one clk of read latency
  always_ff @(posedge clk) begin
    dout   <= mode_ff   ? 12'hFFF : ramaddrb[11:0];
    dout_s <= mode_s_ff ? 12'hFFF : ramaddrb_s[11:0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks += 10;
    if (ramaddrb !== 19'd0)   begin n_fail++; $display("FAIL %s addr: got %0d want 0", tag, ramaddrb); end
    if (rgb !== 12'h000)      begin n_fail++; $display("FAIL %s rgb: got %h want 000", tag, rgb); end
    if (vga_hs !== 1'b1)      begin n_fail++; $display("FAIL %s hs: got %b want 1", tag, vga_hs); end
    if (vga_vs !== 1'b1)      begin n_fail++; $display("FAIL %s vs: got %b want 1", tag, vga_vs); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL %s fs: got %b want 0", tag, frame_start); end
    if (ramaddrb_s !== 19'd0) begin n_fail++; $display("FAIL %s addr_s: got %0d want 0", tag, ramaddrb_s); end
    if (rgb_s !== 12'h000)    begin n_fail++; $display("FAIL %s rgb_s: got %h want 000", tag, rgb_s); end
    if (vga_hs_s !== 1'b1)    begin n_fail++; $display("FAIL %s hs_s: got %b want 1", tag, vga_hs_s); end
    if (vga_vs_s !== 1'b1)    begin n_fail++; $display("FAIL %s vs_s: got %b want 1", tag, vga_vs_s); end
    if (frame_start_s !== 1'b0) begin n_fail++; $display("FAIL %s fs_s: got %b want 0", tag, frame_start_s); end
  endtask

  // Per-clk check of the small instance, starting right after a reset edge.
  // After clk c, m = c/CLK_DIV pixel ticks have happened: counters sit at pixel m,
  // pins show pixel m-1.
  task automatic run_small(input int ncyc, input bit ff, input string tag);
    int m, p, x, y, q, qx, qy;
    bit vis;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;
    for (int c = 1; c <= ncyc; c++) begin
      tick(1);
      m = c / CLK_DIV;
      if (m == 0) begin
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        p = (m - 1) % S_PIX;
        x = p % S_HT;
        y = p / S_HT;
        vis = (x < S_HV) && (y < S_VV);
        e_rgb = vis ? (ff ? 12'hFFF : 12'(y * S_HV + x)) : 12'h000;
        e_hs = !((x >= S_HV + S_HFP) && (x < S_HV + S_HFP + S_HS));
        e_vs = !((y >= S_VV + S_VFP) && (y < S_VV + S_VFP + S_VS));
      end
      e_fs = (c % CLK_DIV == 0) && (m > 0) && (m % S_PIX == 0);
      n_checks += 5;
      if (rgb_s !== e_rgb) begin
        n_fail++; $display("FAIL %s rgb c=%0d: got %h want %h", tag, c, rgb_s, e_rgb);
      end
      if (vga_hs_s !== e_hs) begin
        n_fail++; $display("FAIL %s hs c=%0d: got %b want %b", tag, c, vga_hs_s, e_hs);
      end
      if (vga_vs_s !== e_vs) begin
        n_fail++; $display("FAIL %s vs c=%0d: got %b want %b", tag, c, vga_vs_s, e_vs);
      end
      if (frame_start_s !== e_fs) begin
        n_fail++; $display("FAIL %s frame_start c=%0d: got %b want %b", tag, c, frame_start_s, e_fs);
      end
      if (ramaddrb_s > 19'(S_HV * S_VV - 1)) begin
        n_fail++; $display("FAIL %s addr_range c=%0d: got %0d want <= %0d", tag, c, ramaddrb_s, S_HV * S_VV - 1);
      end
      q = m % S_PIX;
      qx = q % S_HT;
      qy = q / S_HT;
      if ((qx < S_HV) && (qy < S_VV)) begin
        n_checks++;
        if (ramaddrb_s !== 19'(qy * S_HV + qx)) begin
          n_fail++; $display("FAIL %s addr c=%0d: got %0d want %0d", tag, c, ramaddrb_s, qy * S_HV + qx);
        end
      end
    end
  endtask

  task automatic test_reset();
    mode_ff = 1'b1;
    mode_s_ff = 1'b1;
    do_reset();
    check_reset_values("reset");
    tick(3);
    n_checks += 2;
    if (ramaddrb !== 19'd0) begin n_fail++; $display("FAIL pre_tick addr: got %0d want 0", ramaddrb); end
    if (rgb !== 12'h000)    begin n_fail++; $display("FAIL pre_tick rgb: got %h want 000", rgb); end
    tick(1);
    n_checks += 2;
    if (ramaddrb !== 19'd1) begin n_fail++; $display("FAIL first_tick addr: got %0d want 1", ramaddrb); end
    if (rgb !== 12'hFFF)    begin n_fail++; $display("FAIL first_tick rgb: got %h want fff", rgb); end
  endtask

  task automatic test_pixel_data();
    mode_ff = 1'b0;
    do_reset();
    tick(24);
    n_checks += 2;
    if (rgb !== 12'h005)    begin n_fail++; $display("FAIL pix_5_0 rgb: got %h want 005", rgb); end
    if (ramaddrb !== 19'd6) begin n_fail++; $display("FAIL pix_5_0 addr: got %0d want 6", ramaddrb); end
    tick(2560 - 24);
    n_checks++;
    if (rgb !== 12'h27F) begin n_fail++; $display("FAIL pix_639_0 rgb: got %h want 27f", rgb); end
    tick(4);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL pix_640_0 blank rgb: got %h want 000", rgb); end
    tick(3200 - 2564);
    n_checks++;
    if (ramaddrb !== 19'd640) begin n_fail++; $display("FAIL pos_0_1 addr: got %0d want 640", ramaddrb); end
    tick(4);
    n_checks++;
    if (rgb !== 12'h280) begin n_fail++; $display("FAIL pix_0_1 rgb: got %h want 280", rgb); end
  endtask

  task automatic test_line_timing();
    int fall1, fall2, rise1, low_cnt, vs_low;
    logic prev;
    fall1 = -1; fall2 = -1; rise1 = -1; low_cnt = 0; vs_low = 0;
    do_reset();
    prev = vga_hs;
    for (int c = 1; c <= 3 * 3200 + 100; c++) begin
      tick(1);
      if (prev && !vga_hs) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
      if (!prev && vga_hs && rise1 < 0) rise1 = c;
      if (c <= 3200 && !vga_hs) low_cnt++;
      if (!vga_vs) vs_low++;
      prev = vga_hs;
    end
    n_checks += 5;
    if (fall1 !== 2628)        begin n_fail++; $display("FAIL hs_first_fall: got %0d want 2628", fall1); end
    if (rise1 - fall1 !== 384) begin n_fail++; $display("FAIL hs_low_width: got %0d want 384", rise1 - fall1); end
    if (fall2 - fall1 !== 3200) begin n_fail++; $display("FAIL hs_period: got %0d want 3200", fall2 - fall1); end
    if (low_cnt !== 384)       begin n_fail++; $display("FAIL hs_low_count: got %0d want 384", low_cnt); end
    if (vs_low !== 0)          begin n_fail++; $display("FAIL vs_early_lines: got %0d low clks want 0", vs_low); end
  endtask

  task automatic test_blanking();
    mode_s_ff = 1'b1;
    do_reset();
    run_small(2 * S_PIX * CLK_DIV + 20, 1'b1, "blank");
  endtask

  task automatic test_frame_wrap();
    mode_s_ff = 1'b0;
    do_reset();
    run_small(2 * S_PIX * CLK_DIV + 20, 1'b0, "wrap");
  endtask

  // Reset while the small instance shows pixel (10,7): both syncs are low there
  task automatic test_mid_frame_reset();
    mode_ff = 1'b0;
    mode_s_ff = 1'b0;
    do_reset();
    tick(494);
    n_checks += 3;
    if (vga_hs_s !== 1'b0) begin n_fail++; $display("FAIL mid_pre hs_s: got %b want 0", vga_hs_s); end
    if (vga_vs_s !== 1'b0) begin n_fail++; $display("FAIL mid_pre vs_s: got %b want 0", vga_vs_s); end
    if (rgb !== 12'h07A)   begin n_fail++; $display("FAIL mid_pre rgb: got %h want 07a", rgb); end
    rst = 1'b1;
    tick(1);
    check_reset_values("mid_reset");
    rst = 1'b0;
    run_small(S_PIX * CLK_DIV + 20, 1'b0, "after_mid");
  endtask

  initial begin
    test_reset();
    test_pixel_data();
    test_line_timing();
    test_blanking();
    test_frame_wrap();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
